// File: rtl/video_timing_720p_if.sv
// Video timing bundle: raster timing, source-window mapping and the
// line-buffer fetch handshake.
//   master (timing generator): drives everything except line_ack
//   slave  (encoder / line buffer side): drives line_ack
interface video_timing_720p_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        frame_start;
  logic        in_window;
  logic [7:0]  src_x;
  logic [7:0]  src_y;
  logic        line_req;
  logic [7:0]  line_y;
  logic        line_ack;
  logic        underrun;

  modport master (
    output hsync, vsync, de, cx, cy, frame_start, in_window, src_x, src_y,
    output line_req, line_y, underrun,
    input  line_ack
  );

  modport slave (
    input  hsync, vsync, de, cx, cy, frame_start, in_window, src_x, src_y,
    input  line_req, line_y, underrun,
    output line_ack
  );
endinterface

// File: rtl/video_timing_720p.sv
// 1280x720p60 raster timing generator on the 74.25 MHz pixel clock.
// Produces hsync/vsync/de, maps a centred SCALE-x window onto source
// coordinates, and requests each source line from the line buffer during
// the preceding hblank.
// Ports:
//   clk    pixel clock
//   reset  asynchronous, active-high
//   vid    timing bundle (master): hsync, vsync, de, cx, cy, frame_start,
//          in_window, src_x, src_y, line_req, line_y, underrun; line_ack in
module video_timing_720p #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter int unsigned SRC_W    = 240,
  parameter int unsigned SRC_H    = 160,
  parameter int unsigned SCALE    = 4
) (
  input  logic                clk,
  input  logic                reset,
  video_timing_720p_if.master vid
);

  localparam int unsigned SW = $clog2(SCALE);

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HSB = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] XO  = 11'((H_ACTIVE - SRC_W * SCALE) / 2);
  localparam logic [10:0] XE  = 11'((H_ACTIVE - SRC_W * SCALE) / 2 + SRC_W * SCALE);
  localparam logic [9:0]  VA  = 10'(V_ACTIVE);
  localparam logic [9:0]  VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  VSB = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VSE = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  YO  = 10'((V_ACTIVE - SRC_H * SCALE) / 2);
  localparam logic [9:0]  YE  = 10'((V_ACTIVE - SRC_H * SCALE) / 2 + SRC_H * SCALE);
  localparam logic [SW-1:0] SC1 = SW'(SCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_e;

  // Raster state
  logic          run_q;
  logic [10:0]   cx_q, cx_d;
  logic [9:0]    cy_q, cy_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic          inw_q, inw_d;
  logic [7:0]    sx_q, sx_d;
  logic [7:0]    sy_q, sy_d;
  logic [SW-1:0] subx_q, subx_d;
  logic [SW-1:0] suby_q, suby_d;

  // Request FSM state
  req_state_e    state_q, state_d;
  logic [7:0]    line_y_q, line_y_d;
  logic [7:0]    rl_q, rl_d;
  logic [9:0]    req_n_q, req_n_d;
  logic [SW-1:0] tph_q, tph_d;
  logic          underrun_q, underrun_d;

  logic          h_win, v_win;
  logic [9:0]    n_line;
  logic          n_win;
  logic          trig_col;
  logic [SW-1:0] phase;

  // All outputs are computed from the position being entered (cx_d/cy_d)
  // so they register in step with cx/cy. The first edge after reset
  // presents (0,0) rather than advancing past it.
  always_comb begin
    cx_d   = '0;
    cy_d   = '0;
    sx_d   = sx_q;
    sy_d   = sy_q;
    subx_d = subx_q;
    suby_d = suby_q;
    if (run_q) begin
      if (cx_q == HT1) begin
        cx_d = '0;
        cy_d = (cy_q == VT1) ? '0 : cy_q + 10'd1;
      end else begin
        cx_d = cx_q + 11'd1;
        cy_d = cy_q;
      end
    end

    h_win = (cx_d >= XO) && (cx_d < XE);
    v_win = (cy_d >= YO) && (cy_d < YE);
    de_d  = (cx_d < HA) && (cy_d < VA);
    hs_d  = (cx_d >= HSB) && (cx_d < HSE);
    vs_d  = (cy_d >= VSB) && (cy_d < VSE);
    fs_d  = (cx_d == '0) && (cy_d == '0);
    inw_d = h_win && v_win;

    // Sub-counters step the source coordinates every SCALE pixels/lines;
    // src_y advances once per line at the window's left edge.
    if (inw_d) begin
      if (cx_d == XO) begin
        sx_d   = '0;
        subx_d = '0;
        if (cy_d == YO) begin
          sy_d   = '0;
          suby_d = '0;
        end else if (suby_q == SC1) begin
          suby_d = '0;
          sy_d   = sy_q + 8'd1;
        end else begin
          suby_d = suby_q + SW'(1);
        end
      end else if (subx_q == SC1) begin
        subx_d = '0;
        sx_d   = sx_q + 8'd1;
      end else begin
        subx_d = subx_q + SW'(1);
      end
    end

    n_line   = (cy_d == VT1) ? '0 : cy_d + 10'd1;
    n_win    = (n_line >= YO) && (n_line < YE);
    trig_col = (cx_d == HA);
    // Phase of the next line within its SCALE group, tracked line by line
    // at the trigger column instead of dividing.
    if (n_line == YO)      phase = '0;
    else if (tph_q == SC1) phase = '0;
    else                   phase = tph_q + SW'(1);
  end

  always_comb begin
    state_d    = state_q;
    line_y_d   = line_y_q;
    rl_d       = rl_q;
    req_n_d    = req_n_q;
    tph_d      = tph_q;
    underrun_d = 1'b0;

    if (trig_col) tph_d = phase;

    unique case (state_q)
      IDLE: begin
        if (trig_col && n_win && (phase == '0)) begin
          state_d  = REQ;
          line_y_d = (n_line == YO) ? '0 : rl_q;
          rl_d     = ((n_line == YO) ? 8'd0 : rl_q) + 8'd1;
          req_n_d  = n_line;
        end
      end
      REQ: begin
        // An ack on the deadline edge still wins over the underrun.
        if (vid.line_ack) begin
          state_d = IDLE;
        end else if ((cx_d == XO) && (cy_d == req_n_q)) begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      de_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      fs_q       <= 1'b0;
      inw_q      <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      subx_q     <= '0;
      suby_q     <= '0;
      state_q    <= IDLE;
      line_y_q   <= '0;
      rl_q       <= '0;
      req_n_q    <= '0;
      tph_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
      inw_q      <= inw_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      subx_q     <= subx_d;
      suby_q     <= suby_d;
      state_q    <= state_d;
      line_y_q   <= line_y_d;
      rl_q       <= rl_d;
      req_n_q    <= req_n_d;
      tph_q      <= tph_d;
      underrun_q <= underrun_d;
    end
  end

  assign vid.cx          = cx_q;
  assign vid.cy          = cy_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hs_q;
  assign vid.vsync       = vs_q;
  assign vid.frame_start = fs_q;
  assign vid.in_window   = inw_q;
  assign vid.src_x       = sx_q;
  assign vid.src_y       = sy_q;
  assign vid.line_req    = (state_q == REQ);
  assign vid.line_y      = line_y_q;
  assign vid.underrun    = underrun_q;

endmodule

// File: tb/tb_video_timing_720p.sv
// Bench for video_timing_720p. The 720p instance covers reset, line-0
// timing, the window's first line and the first fetch request. A reduced-
// geometry instance (48x32 total, 32x24 active, 6x4 source at x4, offsets
// 4/4, hsync [36,40), vsync lines 26..27) covers whole-frame behaviour:
// frame period, de count, request sequence, underrun and mid-request reset.
module tb_video_timing_720p;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  video_timing_720p_if va();
  video_timing_720p_if vb();

  video_timing_720p dut (
    .clk   (clk),
    .reset (rst_a),
    .vid   (va)
  );

  video_timing_720p #(
    .H_ACTIVE (32), .H_FP (4), .H_SYNC (4), .H_BP (8),
    .V_ACTIVE (24), .V_FP (2), .V_SYNC (2), .V_BP (4),
    .SRC_W    (6),  .SRC_H (4), .SCALE (4)
  ) dut_s (
    .clk   (clk),
    .reset (rst_b),
    .vid   (vb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_a();
    int unsigned ex, ey, model_err, hs_cnt, hs_first, de_cnt;
    int unsigned rises, req_len, hcnt, unr, ystab_err;
    logic [7:0] held_y;
    bit prev_req, done;
    ex = 0; ey = 0; model_err = 0; hs_cnt = 0; hs_first = 0; de_cnt = 0;
    rises = 0; req_len = 0; hcnt = 0; unr = 0; ystab_err = 0;
    held_y = '0; prev_req = 1'b0; done = 1'b0;

    rst_a = 1'b1;
    va.line_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset_outs", {va.hsync, va.vsync, va.de, va.frame_start, va.in_window,
        va.line_req, va.underrun, |va.cx, |va.cy, |va.src_x, |va.src_y, |va.line_y}, 0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_first_cx", va.cx, 0);
    chk("a_first_cy", va.cy, 0);
    chk("a_first_de", va.de, 1);
    chk("a_first_fs", va.frame_start, 1);

    for (int i = 0; i < 70000 && !done; i++) begin
      if (va.cx != 11'(ex) || va.cy != 10'(ey)) model_err++;
      if (va.de != (ex < 1280 && ey < 720)) model_err++;
      if (va.hsync != (ex >= 1390 && ex < 1430)) model_err++;
      if (va.vsync != (ey >= 725 && ey < 730)) model_err++;
      if (va.frame_start != (ex == 0 && ey == 0)) model_err++;
      if (va.in_window != (ex >= 160 && ex < 1120 && ey >= 40 && ey < 680)) model_err++;

      if (va.cy == 0) begin
        if (va.hsync) begin
          if (hs_cnt == 0) hs_first = va.cx;
          hs_cnt++;
        end
        if (va.de) de_cnt++;
      end
      if (va.cx == 1649 && va.cy == 0) begin
        chk("a_hs_len", hs_cnt, 40);
        chk("a_hs_first", hs_first, 1390);
        chk("a_de_line", de_cnt, 1280);
      end
      if (va.cx == 159 && va.cy == 40) chk("a_win_before", va.in_window, 0);
      if (va.cx == 160 && va.cy == 40) begin
        chk("a_win_first", va.in_window, 1);
        chk("a_srcx_first", va.src_x, 0);
        chk("a_srcy_first", va.src_y, 0);
      end
      if (va.cx == 1119 && va.cy == 40) begin
        chk("a_srcx_last", va.src_x, 239);
        chk("a_srcy_line40", va.src_y, 0);
      end
      if (va.cx == 1120 && va.cy == 40) begin
        chk("a_win_after", va.in_window, 0);
        chk("a_srcx_hold", va.src_x, 239);
      end

      if (va.line_req && !prev_req) begin
        rises++;
        held_y = va.line_y;
        if (rises == 1) begin
          chk("a_req_cx", va.cx, 1280);
          chk("a_req_cy", va.cy, 39);
          chk("a_req_y", va.line_y, 0);
        end
      end
      if (va.line_req) begin
        req_len++;
        if (va.line_y != held_y) ystab_err++;
      end
      if (!va.line_req && prev_req) begin
        chk("a_req_len", req_len, 3);
        req_len = 0;
      end
      if (va.underrun) unr++;
      prev_req = va.line_req;

      if (va.cx == 1649 && va.cy == 40) begin
        done = 1'b1;
      end else begin
        hcnt = va.line_req ? hcnt + 1 : 0;
        va.line_ack = va.line_req && (hcnt == 3);
        @(negedge clk);
        ex = (ex == 1649) ? 0 : ex + 1;
        if (ex == 0) ey = (ey == 749) ? 0 : ey + 1;
      end
    end
    chk("a_reached_end", done, 1);
    chk("a_model", model_err, 0);
    chk("a_req_count", rises, 1);
    chk("a_req_y_stable", ystab_err, 0);
    chk("a_no_underrun", unr, 0);
  endtask

  task automatic run_b();
    int unsigned de_cnt, vs_cnt, vs_first, vs_last, rises, req_len, hcnt;
    int unsigned unr, req_err, unr_cx, unr_cy, post_unr, spur_err, zero_err;
    bit prev_req, prev_unr;
    logic [7:0] withhold;

    rst_b = 1'b1;
    vb.line_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_reset_outs", {vb.hsync, vb.vsync, vb.de, vb.frame_start, vb.in_window,
        vb.line_req, vb.underrun, |vb.cx, |vb.cy, |vb.src_x, |vb.src_y, |vb.line_y}, 0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_first_cx", vb.cx, 0);
    chk("b_first_cy", vb.cy, 0);
    chk("b_first_de", vb.de, 1);
    chk("b_first_fs", vb.frame_start, 1);

    // Frame 0: ack 3 clk after req. Frame 1: ack withheld for line_y=1.
    for (int f = 0; f < 2; f++) begin
      withhold = (f == 1) ? 8'd1 : 8'hFF;
      de_cnt = 0; vs_cnt = 0; vs_first = 999; vs_last = 999; rises = 0;
      req_len = 0; hcnt = 0; unr = 0; req_err = 0; unr_cx = 0; unr_cy = 0;
      post_unr = 0; prev_req = 1'b0; prev_unr = 1'b0;
      for (int i = 0; i < 1536; i++) begin
        if (vb.de) de_cnt++;
        if (vb.vsync) begin
          if (vs_cnt == 0) vs_first = vb.cy;
          vs_last = vb.cy;
          vs_cnt++;
        end
        if (f == 0) begin
          if (vb.cx == 4 && vb.cy == 4) begin
            chk("b_win_first", vb.in_window, 1);
            chk("b_srcx_first", vb.src_x, 0);
            chk("b_srcy_first", vb.src_y, 0);
          end
          if (vb.cx == 27 && vb.cy == 19) begin
            chk("b_srcx_last", vb.src_x, 5);
            chk("b_srcy_last", vb.src_y, 3);
          end
          if (vb.cx == 28 && vb.cy == 19) chk("b_win_right", vb.in_window, 0);
          if (vb.cx == 4 && vb.cy == 20) begin
            chk("b_win_bottom", vb.in_window, 0);
            chk("b_srcy_hold", vb.src_y, 3);
          end
        end
        if (vb.line_req && !prev_req) begin
          if (vb.cx != 11'd32 || vb.cy != 10'(3 + 4 * rises) || vb.line_y != 8'(rises))
            req_err++;
          rises++;
          req_len = 0;
        end
        if (vb.line_req) req_len++;
        if (!vb.line_req && prev_req && vb.line_y != withhold && req_len != 3) req_err++;
        if (prev_unr && vb.line_req) post_unr++;
        if (vb.underrun) begin
          unr++;
          unr_cx = vb.cx;
          unr_cy = vb.cy;
        end
        prev_unr = vb.underrun;
        prev_req = vb.line_req;
        hcnt = vb.line_req ? hcnt + 1 : 0;
        vb.line_ack = vb.line_req && (vb.line_y != withhold) && (hcnt == 3);
        @(negedge clk);
      end
      chk($sformatf("b%0d_period_fs", f), vb.frame_start, 1);
      chk($sformatf("b%0d_period_cx", f), vb.cx, 0);
      chk($sformatf("b%0d_period_cy", f), vb.cy, 0);
      chk($sformatf("b%0d_de_count", f), de_cnt, 768);
      chk($sformatf("b%0d_vs_count", f), vs_cnt, 96);
      chk($sformatf("b%0d_vs_first", f), vs_first, 26);
      chk($sformatf("b%0d_vs_last", f), vs_last, 27);
      chk($sformatf("b%0d_req_count", f), rises, 4);
      chk($sformatf("b%0d_req_seq", f), req_err, 0);
      if (f == 0) begin
        chk("b0_no_underrun", unr, 0);
      end else begin
        chk("b1_underrun_count", unr, 1);
        chk("b1_underrun_cx", unr_cx, 4);
        chk("b1_underrun_cy", unr_cy, 8);
        chk("b1_req_low_after", post_unr, 0);
      end
    end

    // Frame 2: spurious acks while idle, then reset during a pending request.
    spur_err = 0;
    for (int i = 0; i < 176; i++) begin
      if (vb.line_req || vb.underrun || vb.line_y != 8'd3) spur_err++;
      vb.line_ack = (i % 2 == 1);
      @(negedge clk);
    end
    chk("b_spurious_ack", spur_err, 0);
    chk("b2_req", vb.line_req, 1);
    chk("b2_req_y", vb.line_y, 0);
    chk("b2_req_cx", vb.cx, 32);
    chk("b2_req_cy", vb.cy, 3);
    vb.line_ack = 1'b0;
    @(negedge clk);
    chk("b2_req_pending", vb.line_req, 1);
    @(posedge clk);
    #2 rst_b = 1'b1;
    zero_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({vb.hsync, vb.vsync, vb.de, vb.frame_start, vb.in_window, vb.line_req,
           vb.underrun, |vb.cx, |vb.cy, |vb.src_x, |vb.src_y, |vb.line_y} != '0)
        zero_err++;
    end
    chk("b_midreset_zero", zero_err, 0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rel_cx", vb.cx, 0);
    chk("b_rel_cy", vb.cy, 0);
    chk("b_rel_de", vb.de, 1);
    chk("b_rel_fs", vb.frame_start, 1);
    chk("b_rel_req", vb.line_req, 0);

    unr = 0; rises = 0; req_err = 0; prev_req = 1'b0; hcnt = 0;
    for (int i = 0; i < 210; i++) begin
      if (vb.underrun) unr++;
      if (vb.line_req && !prev_req) begin
        rises++;
        if (vb.cx != 11'd32 || vb.cy != 10'd3 || vb.line_y != 8'd0) req_err++;
      end
      prev_req = vb.line_req;
      hcnt = vb.line_req ? hcnt + 1 : 0;
      vb.line_ack = vb.line_req && (hcnt == 3);
      @(negedge clk);
    end
    chk("b_rel_no_underrun", unr, 0);
    chk("b_rel_req_count", rises, 1);
    chk("b_rel_req_pos", req_err, 0);
  endtask

  initial begin
    va.line_ack = 1'b0;
    vb.line_ack = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
